// File: rtl/digit_serial_adder_pkg.sv
// digit_serial_adder_pkg: shared FSM state type and index-width helper
package digit_serial_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Digit index width: clog2(n), never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// digit_serial_adder_if: start/busy/done handshake and operand/result bus
//   start, sub, a, b, cin : request side (master drives)
//   busy, done, s, cout, ovf : response side (slave drives)
interface digit_serial_adder_if #(parameter int WIDTH = 16);

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (output start, sub, a, b, cin, input busy, done, s, cout, ovf);
    modport slave  (input start, sub, a, b, cin, output busy, done, s, cout, ovf);

endinterface

// File: rtl/digit_serial_adder_digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple adder built from full adders
//   i_x, i_y : addend digits        i_ci    : carry in
//   o_sum    : digit sum            o_co    : carry out of the top bit
//   o_c_msb  : carry into the top bit
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_x,
    input  logic [DIGIT-1:0] i_y,
    input  logic             i_ci,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_co,
    output logic             o_c_msb
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = i_ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign o_sum[i]  = i_x[i] ^ i_y[i] ^ w_c[i];
        assign w_c[i+1]  = (i_x[i] & i_y[i]) | (w_c[i] & (i_x[i] ^ i_y[i]));
    end

    assign o_co    = w_c[DIGIT];
    assign o_c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: WIDTH-bit add/subtract, one DIGIT-bit slice per clock
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of digit_serial_adder_if (start/sub/a/b/cin in,
//              busy/done/s/cout/ovf out)
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic                 clk,
    input logic                 rst,
    digit_serial_adder_if.slave bus
);

    localparam int N  = WIDTH / DIGIT;
    localparam int IW = idx_w(N);

    if (DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad_params
        $fatal(1, "digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    state_t            r_state;
    state_t            w_next;
    logic [IW-1:0]     r_idx;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_s;
    logic              r_c;
    logic              r_cout;
    logic              r_ovf;
    logic              w_accept;
    logic              w_last;
    logic [DIGIT-1:0]  w_sum;
    logic              w_co;
    logic              w_c_msb;

    // Operands shift right each RUN cycle, so the live digit is always the LSB slice
    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .i_x     (r_a[DIGIT-1:0]),
        .i_y     (r_b[DIGIT-1:0]),
        .i_ci    (r_c),
        .o_sum   (w_sum),
        .o_co    (w_co),
        .o_c_msb (w_c_msb)
    );

    // DONE accepts a new start just like IDLE, giving back-to-back operation
    always_comb begin
        w_accept = (r_state != RUN) && bus.start;
        w_last   = r_idx == IW'(N - 1);
        w_next   = w_accept ? RUN : (r_state == RUN) ? (w_last ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                // Subtraction as a + ~b + 1; cin then acts as a borrow
                r_a   <= bus.a;
                r_b   <= bus.b ^ {WIDTH{bus.sub}};
                r_c   <= bus.cin ^ bus.sub;
                r_idx <= '0;
            end else if (r_state == RUN) begin
                r_s[r_idx*DIGIT +: DIGIT] <= w_sum;
                r_a   <= r_a >> DIGIT;
                r_b   <= r_b >> DIGIT;
                r_c   <= w_co;
                r_idx <= w_last ? '0 : r_idx + IW'(1);
                if (w_last) begin
                    r_cout <= w_co;
                    r_ovf  <= w_c_msb ^ w_co;
                end
            end
        end
    end

    assign bus.busy = r_state == RUN;
    assign bus.done = r_state == DONE;
    assign bus.s    = r_s;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: scoreboard bench for three adder configurations
module tb_digit_serial_adder;

    typedef struct {
        int          id;
        logic [15:0] s;
        logic        c;
        logic        o;
        int          k;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   bc[3] = '{0, 0, 0};
    exp_t q[$];

    digit_serial_adder_if #(.WIDTH(16)) bus0 ();
    digit_serial_adder_if #(.WIDTH(8))  bus1 ();
    digit_serial_adder_if #(.WIDTH(8))  bus2 ();

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    digit_serial_adder #(.WIDTH(8),  .DIGIT(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    digit_serial_adder #(.WIDTH(8),  .DIGIT(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0h want %0h", n, id, act, exp);
        end
    endtask

    function automatic logic dn(input int id);
        return (id == 0) ? bus0.done : (id == 1) ? bus1.done : bus2.done;
    endfunction

    // Monitor: on every done pulse pop the oldest expectation and compare
    task automatic mon(input int id, input logic busy, input logic done, input logic [15:0] s,
                       input logic c, input logic o, input int n);
        exp_t e;
        if (done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done dut%0d", id);
            end else begin
                e = q.pop_front();
                chk("dut_id", id, 32'(id), 32'(e.id));
                chk("s", id, 32'(s), 32'(e.s));
                chk("cout", id, 32'(c), 32'(e.c));
                chk("ovf", id, 32'(o), 32'(e.o));
                chk("latency", id, cyc - e.k, n);
                chk("busy_cycles", id, bc[id], n);
            end
        end
        bc[id] = busy ? bc[id] + 1 : 0;
    endtask

    always @(negedge clk) begin
        mon(0, bus0.busy, bus0.done, bus0.s, bus0.cout, bus0.ovf, 4);
        mon(1, bus1.busy, bus1.done, 16'(bus1.s), bus1.cout, bus1.ovf, 1);
        mon(2, bus2.busy, bus2.done, 16'(bus2.s), bus2.cout, bus2.ovf, 8);
    end

    // Drive a request for one cycle and push its expected result
    task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic sb, input logic [15:0] es, input logic ec, input logic eo);
        if (id == 0) begin
            bus0.a = a; bus0.b = b; bus0.cin = ci; bus0.sub = sb; bus0.start = 1'b1;
        end else if (id == 1) begin
            bus1.a = a[7:0]; bus1.b = b[7:0]; bus1.cin = ci; bus1.sub = sb; bus1.start = 1'b1;
        end else begin
            bus2.a = a[7:0]; bus2.b = b[7:0]; bus2.cin = ci; bus2.sub = sb; bus2.start = 1'b1;
        end
        q.push_back('{id: id, s: es, c: ec, o: eo, k: cyc + 1});
        @(negedge clk);
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        bus2.start = 1'b0;
    endtask

    task automatic wt(input int id);
        int i = 0;
        while (!dn(id) && i < 40) begin
            @(negedge clk);
            i++;
        end
        if (!dn(id)) begin
            checks++;
            errors++;
            $display("FAIL timeout dut%0d no done", id);
        end
    endtask

    task automatic op(input int id, input logic [15:0] a, input logic [15:0] b, input logic ci,
                      input logic sb, input logic [15:0] es, input logic ec, input logic eo);
        @(negedge clk);
        issue(id, a, b, ci, sb, es, ec, eo);
        wt(id);
    endtask

    initial begin
        rst = 1'b1;
        bus0.start = 0; bus0.sub = 0; bus0.a = '0; bus0.b = '0; bus0.cin = 0;
        bus1.start = 0; bus1.sub = 0; bus1.a = '0; bus1.b = '0; bus1.cin = 0;
        bus2.start = 0; bus2.sub = 0; bus2.a = '0; bus2.b = '0; bus2.cin = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 0, 32'(bus0.busy), 0);
        chk("rst_done", 0, 32'(bus0.done), 0);
        chk("rst_s", 0, 32'(bus0.s), 0);
        chk("rst_cout", 0, 32'(bus0.cout), 0);
        chk("rst_ovf", 0, 32'(bus0.ovf), 0);
        chk("rst_busy", 2, 32'(bus2.busy), 0);
        rst = 1'b0;

        op(0, 16'h0001, 16'h0000, 0, 0, 16'h0001, 0, 0);
        op(0, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
        op(0, 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
        op(0, 16'h0005, 16'h0003, 0, 1, 16'h0002, 1, 0);
        op(0, 16'h0003, 16'h0005, 0, 1, 16'hFFFE, 0, 0);
        op(0, 16'h0010, 16'h0001, 1, 1, 16'h000E, 1, 0);

        // Ignored start mid-RUN, then a second start in the DONE cycle
        @(negedge clk);
        issue(0, 16'h00B0, 16'h0060, 0, 0, 16'h0110, 0, 0);
        @(negedge clk);
        bus0.a = 16'hFFFF; bus0.b = 16'hFFFF; bus0.cin = 1; bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        wt(0);
        issue(0, 16'h0005, 16'h0003, 1, 0, 16'h0009, 0, 0);
        wt(0);

        // Leave nonzero s/cout/ovf, then abort an operation with reset after two digits
        op(0, 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);
        @(negedge clk);
        issue(0, 16'h1234, 16'h1111, 0, 0, 16'h2345, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 0, 32'(bus0.busy), 0);
        chk("abort_done", 0, 32'(bus0.done), 0);
        chk("abort_s", 0, 32'(bus0.s), 0);
        chk("abort_cout", 0, 32'(bus0.cout), 0);
        chk("abort_ovf", 0, 32'(bus0.ovf), 0);
        repeat (10) @(negedge clk);
        op(0, 16'h1234, 16'h1111, 0, 0, 16'h2345, 0, 0);

        op(1, 16'h000B, 16'h0006, 0, 0, 16'h0011, 0, 0);
        op(1, 16'h0080, 16'h0080, 0, 0, 16'h0000, 1, 1);
        op(2, 16'h000B, 16'h0006, 0, 0, 16'h0011, 0, 0);
        op(2, 16'h007F, 16'h0001, 0, 0, 16'h0080, 0, 1);
        op(2, 16'h0000, 16'h0001, 0, 1, 16'h00FF, 0, 0);

        repeat (5) @(negedge clk);
        chk("queue_empty", 0, 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
